// File: rtl/ofm_write_scheduler_if.sv
// ofm_write_scheduler_if: tile handshake from the array output buffer and the OFM RAM write port.
interface ofm_write_scheduler_if #(
    parameter int SYSTOLIC_SIZE = 16
);
    logic tile_valid;
    logic tile_ready;
    logic ram_stall;
    logic write;
    logic ofm_we;
    logic [$clog2(SYSTOLIC_SIZE)-1:0] row_sel;
    modport master (input tile_valid, ram_stall, output tile_ready, write, ofm_we, row_sel);
    modport slave (output tile_valid, ram_stall, input tile_ready, write, ofm_we, row_sel);
endinterface

// File: rtl/ofm_write_scheduler.sv
// ofm_write_scheduler: sequences per-tile OFM RAM row writes for one layer, with a post-tile gap.
module ofm_write_scheduler #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [13:0]                  num_tiling,
    input  logic [4:0]                   read_wgt_size,
    ofm_write_scheduler_if.master        bus,
    output logic [13:0]                  tile_count,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err
);
    localparam int RW = $clog2(SYSTOLIC_SIZE);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, WAIT_TILE, WRITE, GAP, FINISH} state_t;
    state_t state, state_d;
    logic [13:0] ntile_q, ntile_d, count_d;
    logic [4:0] rws_q, rws_d;
    logic [RW-1:0] row_d;
    logic [GW-1:0] gap_q, gap_d;
    logic write_d, we_d, busy_d, done_d, err_d;
    logic hs, last_row, last_gap, bad_cfg;
    assign bus.tile_ready = (state == WAIT_TILE) && !bus.ram_stall;
    assign hs       = bus.tile_valid && bus.tile_ready;
    assign last_row = 32'(bus.row_sel) == 32'(rws_q) - 32'd1;
    assign last_gap = gap_q == GW'(GAP_CYCLES - 1);
    assign bad_cfg  = read_wgt_size == 5'd0 || 32'(read_wgt_size) > SYSTOLIC_SIZE;
    always_comb begin
        state_d = state;
        ntile_d = ntile_q;
        rws_d   = rws_q;
        count_d = tile_count;
        row_d   = bus.row_sel;
        gap_d   = gap_q;
        write_d = 1'b0;
        we_d    = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;
        err_d   = cfg_err;
        case (state)
            IDLE: if (start) begin
                if (bad_cfg) err_d = 1'b1;
                else if (num_tiling == 14'd0) done_d = 1'b1;
                else begin
                    ntile_d = num_tiling;
                    rws_d   = read_wgt_size;
                    count_d = 14'd0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = WAIT_TILE;
                end
            end
            WAIT_TILE: if (hs) begin
                state_d = WRITE;
                write_d = 1'b1;
                we_d    = 1'b1;
                row_d   = '0;
            end
            // outputs are registered, so the row being driven now is bus.row_sel
            WRITE: if (last_row) begin
                state_d = GAP;
                count_d = tile_count + 14'd1;
                gap_d   = '0;
            end else begin
                we_d  = 1'b1;
                row_d = bus.row_sel + RW'(1);
            end
            GAP: if (last_gap) state_d = (tile_count == ntile_q) ? FINISH : WAIT_TILE;
                 else gap_d = gap_q + GW'(1);
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ntile_q     <= '0;
            rws_q       <= '0;
            tile_count  <= '0;
            bus.row_sel <= '0;
            gap_q       <= '0;
            bus.write   <= 1'b0;
            bus.ofm_we  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state       <= state_d;
            ntile_q     <= ntile_d;
            rws_q       <= rws_d;
            tile_count  <= count_d;
            bus.row_sel <= row_d;
            gap_q       <= gap_d;
            bus.write   <= write_d;
            bus.ofm_we  <= we_d;
            busy        <= busy_d;
            done        <= done_d;
            cfg_err     <= err_d;
        end
    end
endmodule

// File: tb/tb_ofm_write_scheduler.sv
// tb_ofm_write_scheduler: directed cycle-by-cycle checks of tile sequencing, stalls, config errors and reset.
module tb_ofm_write_scheduler;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [13:0] num_tiling = '0;
    logic [4:0] read_wgt_size = '0;
    logic [13:0] tile_count;
    logic busy, done, cfg_err;
    int tests = 0, fails = 0, nwr = 0, nwe = 0, w0, e0;
    ofm_write_scheduler_if #(.SYSTOLIC_SIZE(16)) bus ();
    ofm_write_scheduler #(.SYSTOLIC_SIZE(16), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .num_tiling(num_tiling),
        .read_wgt_size(read_wgt_size), .bus(bus), .tile_count(tile_count),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.write === 1'b1) nwr++;
        if (bus.ofm_we === 1'b1) nwe++;
    end
    // enter the next cycle and drive this cycle's handshake inputs
    task automatic cyc(input logic s, input logic tv, input logic st);
        @(posedge clk);
        #1;
        start = s;
        bus.tile_valid = tv;
        bus.ram_stall = st;
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    initial begin
        bus.tile_valid = 1'b0;
        bus.ram_stall = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_we", bus.ofm_we, 0);
        chk("rst_wr", bus.write, 0);
        chk("rst_row", bus.row_sel, 0);
        chk("rst_cnt", tile_count, 0);
        chk("rst_rdy", bus.tile_ready, 0);
        rst = 1'b0;
        // basic layer: 2 tiles x 4 rows
        num_tiling = 14'd2; read_wgt_size = 5'd4; w0 = nwr; e0 = nwe;
        cyc(1, 1, 0);
        chk("b_rdy_idle", bus.tile_ready, 0);
        cyc(0, 1, 0);
        chk("b_busy", busy, 1);
        chk("b_rdy", bus.tile_ready, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0);
            chk("b_wr", bus.write, 32'(i == 0));
            chk("b_we", bus.ofm_we, 1);
            chk("b_row", bus.row_sel, i);
        end
        cyc(0, 1, 0);
        chk("b_gap_we", bus.ofm_we, 0);
        chk("b_cnt1", tile_count, 1);
        chk("b_gap_rdy0", bus.tile_ready, 0);
        cyc(0, 1, 0);
        chk("b_gap_rdy1", bus.tile_ready, 0);
        cyc(0, 1, 0);
        chk("b_rdy2", bus.tile_ready, 1);
        cyc(0, 0, 0);
        chk("b_wr2", bus.write, 1);
        repeat (3) cyc(0, 0, 0);
        chk("b_row3", bus.row_sel, 3);
        cyc(0, 0, 0);
        chk("b_cnt2", tile_count, 2);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("b_done15", done, 0);
        chk("b_busy15", busy, 1);
        cyc(0, 0, 0);
        chk("b_done16", done, 1);
        chk("b_busy16", busy, 0);
        chk("b_cnt_hold", tile_count, 2);
        cyc(0, 0, 0);
        chk("b_done_pulse", done, 0);
        chk("b_nwr", nwr - w0, 2);
        chk("b_nwe", nwe - e0, 8);
        // stall in WAIT_TILE for 5 cycles, then stall during WRITE
        num_tiling = 14'd1; read_wgt_size = 5'd4; w0 = nwr; e0 = nwe;
        cyc(1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 1);
            chk("s_rdy", bus.tile_ready, 0);
            chk("s_wr", bus.write, 0);
        end
        cyc(0, 1, 0);
        chk("s_rdy_release", bus.tile_ready, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1);
            chk("s_we", bus.ofm_we, 1);
            chk("s_row", bus.row_sel, i);
        end
        cyc(0, 0, 0);
        chk("s_cnt", tile_count, 1);
        repeat (3) cyc(0, 0, 0);
        chk("s_done", done, 1);
        chk("s_nwr", nwr - w0, 1);
        chk("s_nwe", nwe - e0, 4);
        // full 16-row tile
        num_tiling = 14'd1; read_wgt_size = 5'd16; w0 = nwr; e0 = nwe;
        cyc(1, 1, 0);
        cyc(0, 1, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0);
            chk("f_we", bus.ofm_we, 1);
            chk("f_row", bus.row_sel, i);
        end
        cyc(0, 0, 0);
        chk("f_gap_we", bus.ofm_we, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("f_done20", done, 0);
        cyc(0, 0, 0);
        chk("f_done21", done, 1);
        chk("f_cnt", tile_count, 1);
        chk("f_nwr", nwr - w0, 1);
        chk("f_nwe", nwe - e0, 16);
        // bad config and empty layer
        num_tiling = 14'd3; read_wgt_size = 5'd0; w0 = nwr; e0 = nwe;
        cyc(1, 1, 0);
        cyc(0, 1, 0);
        chk("c_err0", cfg_err, 1);
        chk("c_busy0", busy, 0);
        chk("c_rdy0", bus.tile_ready, 0);
        read_wgt_size = 5'd17;
        cyc(1, 1, 0);
        cyc(0, 1, 0);
        chk("c_err17", cfg_err, 1);
        chk("c_busy17", busy, 0);
        num_tiling = 14'd0; read_wgt_size = 5'd4;
        cyc(1, 1, 0);
        cyc(0, 1, 0);
        chk("c_zero_done", done, 1);
        chk("c_zero_busy", busy, 0);
        cyc(0, 0, 0);
        chk("c_zero_done2", done, 0);
        chk("c_nwr", nwr - w0, 0);
        chk("c_nwe", nwe - e0, 0);
        // start while busy ignored; tile_valid during GAP held off
        num_tiling = 14'd2; read_wgt_size = 5'd2;
        cyc(1, 1, 0);
        cyc(0, 1, 0);
        chk("i_err_clr", cfg_err, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        num_tiling = 14'd5; read_wgt_size = 5'd8;
        cyc(1, 1, 0);
        chk("i_gap_rdy0", bus.tile_ready, 0);
        chk("i_cnt1", tile_count, 1);
        cyc(0, 1, 0);
        chk("i_gap_rdy1", bus.tile_ready, 0);
        chk("i_cnt_kept", tile_count, 1);
        cyc(0, 1, 0);
        chk("i_rdy", bus.tile_ready, 1);
        cyc(0, 0, 0);
        chk("i_wr", bus.write, 1);
        cyc(0, 0, 0);
        chk("i_row1", bus.row_sel, 1);
        cyc(0, 0, 0);
        chk("i_we_end", bus.ofm_we, 0);
        chk("i_cnt2", tile_count, 2);
        repeat (3) cyc(0, 0, 0);
        chk("i_done", done, 1);
        chk("i_cnt_final", tile_count, 2);
        // reset during the second tile's WRITE, then a fresh layer
        num_tiling = 14'd3; read_wgt_size = 5'd4;
        cyc(1, 1, 0);
        repeat (5) cyc(0, 1, 0);
        cyc(0, 1, 0);
        chk("r_cnt1", tile_count, 1);
        repeat (2) cyc(0, 1, 0);
        repeat (3) cyc(0, 0, 0);
        chk("r_row2", bus.row_sel, 2);
        chk("r_we_pre", bus.ofm_we, 1);
        rst = 1'b1;
        cyc(0, 0, 0);
        rst = 1'b0;
        chk("r_we", bus.ofm_we, 0);
        chk("r_busy", busy, 0);
        chk("r_cnt", tile_count, 0);
        chk("r_wr", bus.write, 0);
        cyc(0, 0, 0);
        chk("r_we_after", bus.ofm_we, 0);
        num_tiling = 14'd1; read_wgt_size = 5'd3; w0 = nwr; e0 = nwe;
        cyc(1, 1, 0);
        cyc(0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            chk("r2_row", bus.row_sel, i);
            chk("r2_we", bus.ofm_we, 1);
        end
        cyc(0, 0, 0);
        chk("r2_cnt", tile_count, 1);
        repeat (3) cyc(0, 0, 0);
        chk("r2_done", done, 1);
        chk("r2_busy", busy, 0);
        chk("r2_nwr", nwr - w0, 1);
        chk("r2_nwe", nwe - e0, 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ofm_write_scheduler.md
Name: ofm_write_scheduler

Overview:
- Sequences write-back of systolic-array result tiles into OFM RAM for one layer.
- Accepts one tile at a time from the array output buffer over a valid/ready handshake.
- Per tile: one-cycle `write` pulse to the OFM write address controller, then row-by-row RAM write enables with a row select.
- Counts tiles against the layer's tiling count, signals layer completion, and enforces the post-tile gap the address controller needs to update its base address.

Parameters:
- SYSTOLIC_SIZE, 16, max rows per tile; row_sel width = $clog2(SYSTOLIC_SIZE).
- GAP_CYCLES, 2, idle cycles after each tile's last row; must be >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse; latches config and begins a layer.
- num_tiling  input  14  tiles in the layer; sampled on an accepted start.
- read_wgt_size  input  5  rows per tile (1..SYSTOLIC_SIZE); sampled on an accepted start.
- tile_valid  input  1  array output buffer holds a complete tile.
- tile_ready  output  1  scheduler accepts a tile this cycle.
- ram_stall  input  1  OFM RAM unavailable; blocks tile acceptance only.
- write  output  1  one-cycle pulse to the address controller at the first row of each tile.
- ofm_we  output  1  OFM RAM write enable.
- row_sel  output  $clog2(SYSTOLIC_SIZE)  buffer row being written.
- tile_count  output  14  tiles fully written in the current layer.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle completion pulse.
- cfg_err  output  1  sticky error for a rejected configuration.

Behaviour:
- Reset: on a clk edge with rst=1, state=IDLE. All of write, ofm_we, row_sel, tile_count, busy, done and cfg_err are 0. Latched config is 0.
- Reset mid-layer aborts immediately. No further write or ofm_we. The next start begins a fresh layer.
- tile_ready is combinational: (state==WAIT_TILE) && !ram_stall. Handshake = tile_valid && tile_ready.
- Every output other than tile_ready is registered.
- IDLE:
  - start accepted here only; start in any other state is ignored.
  - start with read_wgt_size==0 or >SYSTOLIC_SIZE: cfg_err<=1, stay IDLE.
  - start with num_tiling==0: busy stays 0, done pulses on the next cycle.
  - Otherwise: latch config, tile_count<=0, cfg_err<=0, busy<=1, go to WAIT_TILE.
- WAIT_TILE: on handshake go to WRITE. ram_stall only delays acceptance; it has no effect once WRITE begins.
- WRITE: lasts exactly read_wgt_size cycles.
  - First cycle: write=1, ofm_we=1, row_sel=0.
  - Later cycles: write=0, ofm_we=1, row_sel increments by 1, ending at read_wgt_size-1.
  - On the last cycle tile_count increments. Then go to GAP.
- GAP: GAP_CYCLES cycles, ofm_we=0, tile_ready=0; tile_valid is held off.
  - On exit: if tile_count==latched num_tiling go to FINISH, else WAIT_TILE.
- FINISH: one cycle. done=1, busy<=0, then IDLE. tile_count holds until the next accepted start.
- Latency: handshake at cycle N gives write/ofm_we at N+1. Per-tile occupancy is read_wgt_size+GAP_CYCLES cycles, plus at least 1 WAIT_TILE cycle.
- Back-to-back tiles: with tile_valid held high and no stall, the next handshake occurs in the first WAIT_TILE cycle after GAP.
- tile_count is 14 bits and cannot overflow, since num_tiling <= 16383.
- Config inputs changing while busy have no effect until the next accepted start.

Test Plan:
- Basic layer: start, num_tiling=2, read_wgt_size=4, tile_valid held 1 -> handshake at cycle 1. write at cycle 2. ofm_we cycles 2-5 with row_sel 0,1,2,3. Gap cycles 6-7. Second handshake at cycle 8. done pulses once at cycle 16. tile_count=2.
- Stall: ram_stall=1 for 5 cycles while tile_valid=1 in WAIT_TILE -> tile_ready=0 and no write during the stall. Handshake in the first cycle ram_stall=0. Assert ram_stall during WRITE -> all 4 ofm_we cycles still occur.
- Full tile: read_wgt_size=16, num_tiling=1 -> 16 contiguous ofm_we cycles, row_sel 0..15, exactly one write pulse. done 2 cycles after GAP start+1 (FINISH).
- Boundary config: read_wgt_size=0 -> cfg_err=1, busy=0, no ofm_we. num_tiling=0 with read_wgt_size=4 -> done pulse one cycle after start, no write.
- Start while busy, and tile_valid asserted during GAP -> second start ignored (config unchanged, tile_count not cleared). tile_ready=0 throughout GAP.
- Reset mid-WRITE: rst=1 at row_sel=2 -> next cycle ofm_we=0, busy=0, tile_count=0. A new start then runs a full layer correctly.
